// File: rtl/systolic_seq_ctrl.sv
// Sequencing controller for a SIZE x SIZE output-stationary systolic MAC array:
// holds A/B tiles, clears the array, feeds skewed rows/columns, drains, then pulses done.
module systolic_seq_ctrl #(
  parameter int SIZE         = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(SIZE)-1:0]    wr_row,
  input  logic [$clog2(SIZE)-1:0]    wr_col,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       array_rst,
  output logic [SIZE*DATA_WIDTH-1:0] west_data,
  output logic [SIZE*DATA_WIDTH-1:0] north_data
);

  localparam int IW = $clog2(SIZE);
  localparam int TW = $clog2(3*SIZE);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(3*SIZE-3);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             t_q, t_d;
  logic [CW-1:0]             drn_q, drn_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      array_rst_q, array_rst_d;
  logic [SIZE*DATA_WIDTH-1:0] west_q, west_d;
  logic [SIZE*DATA_WIDTH-1:0] north_q, north_d;

  logic [DATA_WIDTH-1:0] a_q [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_q [SIZE][SIZE];

  int unsigned tv;

  // Tile storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && wr_en) begin
      if (wr_sel) b_q[wr_row][wr_col] <= wr_data;
      else        a_q[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == D_LAST) state_d = DONE;
        else                 drn_d   = drn_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered values line up with the state they belong to.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    array_rst_d = (state_d == CLEAR);
    west_d      = '0;
    north_d     = '0;
    tv          = 32'(t_d);
    if (state_d == FEED) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (tv >= i && tv < i + SIZE) begin
          west_d[i*DATA_WIDTH +: DATA_WIDTH]  = a_q[IW'(i)][IW'(tv - i)];
          north_d[i*DATA_WIDTH +: DATA_WIDTH] = b_q[IW'(tv - i)][IW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      drn_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      array_rst_q <= 1'b1;
      west_q      <= '0;
      north_q     <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      drn_q       <= drn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      array_rst_q <= array_rst_d;
      west_q      <= west_d;
      north_q     <= north_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign array_rst  = array_rst_q;
  assign west_data  = west_q;
  assign north_data = north_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a behavioural PE array integrates the lanes, and a
// scoreboard checks done latency and final array results; lanes are checked directly.
module tb_systolic_seq_ctrl;

  localparam int SIZE  = 4;
  localparam int DW    = 32;
  localparam int DRAIN = 2;
  localparam int NRES  = SIZE*SIZE*32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic                 wr_sel;
  logic [1:0]           wr_row;
  logic [1:0]           wr_col;
  logic [DW-1:0]        wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 array_rst;
  logic [SIZE*DW-1:0]   west_data;
  logic [SIZE*DW-1:0]   north_data;

  systolic_seq_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .array_rst(array_rst), .west_data(west_data), .north_data(north_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural output-stationary array driven by the DUT lanes.
  int            acc [SIZE][SIZE];
  logic [DW-1:0] ar  [SIZE][SIZE];
  logic [DW-1:0] br  [SIZE][SIZE];

  always @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        logic [DW-1:0] ai, bi;
        if (j == 0) ai = west_data[i*DW +: DW];
        else        ai = ar[i][j-1];
        if (i == 0) bi = north_data[j*DW +: DW];
        else        bi = br[i-1][j];
        if (array_rst) begin
          acc[i][j] <= 0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
          ar[i][j]  <= ai;
          br[i][j]  <= bi;
        end
      end
    end
  end

  typedef struct packed {
    logic [31:0]     cyc;
    logic [NRES-1:0] res;
  } exp_t;

  exp_t sbq [$];

  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_latency_cycle", 128'(cyc), 128'(e.cyc));
        chk("busy_with_done", 128'(busy), 128'(1'b1));
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++)
            chk($sformatf("result_%0d_%0d", i, j), 128'(acc[i][j]),
                128'(e.res[(i*SIZE+j)*32 +: 32]));
      end
    end
  end

  function automatic logic [NRES-1:0] mat_const(input int v);
    logic [NRES-1:0] m;
    for (int k = 0; k < SIZE*SIZE; k++) m[k*32 +: 32] = 32'(v);
    return m;
  endfunction

  task automatic wr(input logic sel, input int r, input int c, input int d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = 32'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start in the current (IDLE) cycle; done must appear 14 cycles later.
  task automatic launch(input bit push, input logic [NRES-1:0] res);
    exp_t e;
    start = 1'b1;
    if (push) begin
      e.cyc = 32'(cyc + 14);
      e.res = res;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk("clear_array_rst", 128'(array_rst), 128'(1'b1));
    chk("clear_busy", 128'(busy), 128'(1'b1));
  endtask

  task automatic wait_done_then_idle();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 128'(done), 128'(1'b1));
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'(1'b0));
    chk("idle_done", 128'(done), 128'(1'b0));
  endtask

  function automatic logic [DW-1:0] lane(input logic [SIZE*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  logic [NRES-1:0] m;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_array_rst", 128'(array_rst), 128'(1'b1));
    chk("rst_west", 128'(west_data), 128'(0));
    chk("rst_north", 128'(north_data), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_array_rst", 128'(array_rst), 128'(1'b0));

    // Identity x B: result equals B.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        wr(1'b0, r, c, (r == c) ? 1 : 0);
        wr(1'b1, r, c, 4*r + c + 1);
      end
    for (int k = 0; k < SIZE*SIZE; k++) m[k*32 +: 32] = 32'(k + 1);
    launch(1'b1, m);
    for (int t = 0; t < 3*SIZE-2; t++) begin
      @(negedge clk);
      if (t == 0) begin
        chk("id_t0_west", 128'(west_data), 128'(1));
        chk("id_t0_north", 128'(north_data), 128'(1));
      end
      if (t == 3) begin
        chk("id_t3_west", 128'(west_data), 128'(0));
        chk("id_t3_north0", 128'(lane(north_data, 0)), 128'(13));
        chk("id_t3_north1", 128'(lane(north_data, 1)), 128'(10));
        chk("id_t3_north2", 128'(lane(north_data, 2)), 128'(7));
        chk("id_t3_north3", 128'(lane(north_data, 3)), 128'(4));
      end
    end
    wait_done_then_idle();

    // Skew: A all 2, B all 3.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        wr(1'b0, r, c, 2);
        wr(1'b1, r, c, 3);
      end
    launch(1'b1, mat_const(24));
    for (int t = 0; t < 3*SIZE-2; t++) begin
      @(negedge clk);
      for (int i = 0; i < SIZE; i++) begin
        chk($sformatf("skew_west_t%0d_l%0d", t, i), 128'(lane(west_data, i)),
            128'((t >= i && t <= i + 3) ? 2 : 0));
        chk($sformatf("skew_north_t%0d_l%0d", t, i), 128'(lane(north_data, i)),
            128'((t >= i && t <= i + 3) ? 3 : 0));
      end
    end
    wait_done_then_idle();

    // Start and write while busy are ignored.
    launch(1'b1, mat_const(24));
    repeat (3) @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 32'd99;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done_then_idle();
    launch(1'b1, mat_const(24));
    wait_done_then_idle();

    // Reset during FEED at t=5: no done, then a clean rerun.
    launch(1'b0, '0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    chk("midrst_done", 128'(done), 128'(1'b0));
    chk("midrst_array_rst", 128'(array_rst), 128'(1'b1));
    chk("midrst_west", 128'(west_data), 128'(0));
    chk("midrst_north", 128'(north_data), 128'(0));
    repeat (16) @(negedge clk);
    chk("midrst_still_idle", 128'(busy), 128'(1'b0));
    launch(1'b1, mat_const(24));
    wait_done_then_idle();

    // Back-to-back: start in the IDLE cycle right after done, with a same-cycle write.
    launch(1'b1, mat_const(24));
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (done !== 1'b1) chk("b2b_done_timeout", 128'(done), 128'(1'b1));
    end
    @(negedge clk);
    m = mat_const(24);
    for (int j = 0; j < SIZE; j++) m[j*32 +: 32] = 32'd33;
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 32'd5;
    launch(1'b1, m);
    wait_done_then_idle();

    begin
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (sbq.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
